// File: rtl/dec2to4_en.sv
`default_nettype none
// ============================================================================
//  Module   : dec2to4_en
//  Purpose  : 2-to-4 line decoder with active-high enable and selectable
//             output polarity. By default, the decoded word and the "line
//             asserted" flag are registered, giving one clock of latency.
//             If DEC2TO4_COMB_OUT_EN is defined at build time, both outputs
//             become purely combinational from code/en.
//  Ports    : clk    in   1  rising-edge clock
//             reset  in   1  synchronous active-high reset
//             code   in   2  binary line select, 0..3
//             en     in   1  decode enable, active-high
//             out    out  4  one-hot decoded word (inverted when INV_OUT=1)
//             any    out  1  high while a line is being asserted
//  Params   : INV_OUT  0 = active-high one-hot, 1 = active-low one-hot
//  Macro    : DEC2TO4_COMB_OUT_EN  selects zero-latency combinational outputs
//  Revision : 1.0  initial release
// ============================================================================
module dec2to4_en #(
  parameter int INV_OUT = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] code,
  input  logic       en,
  output logic [3:0] out,
  output logic       any
);

  // Active-high one-hot decode. A disabled decoder yields all zeros, so at
  // most one bit can ever be set, independent of the code value.
  logic [3:0] w_dec_hi;
  logic [3:0] w_dec;
  logic [3:0] c_idle;

  assign w_dec_hi = en ? (4'b0001 << code) : 4'b0000;

  // Polarity is a build-time choice, so it is resolved here rather than
  // muxed at run time. c_idle is the all-inactive word for this polarity.
  generate
    if (INV_OUT != 0) begin : g_active_low
      assign w_dec  = ~w_dec_hi;
      assign c_idle = 4'b1111;
    end else begin : g_active_high
      assign w_dec  = w_dec_hi;
      assign c_idle = 4'b0000;
    end
  endgenerate

`ifdef DEC2TO4_COMB_OUT_EN

  // Zero-latency variant. clk and reset stay on the port list so both builds
  // share the same footprint. They are folded into a sink here because they
  // do not affect the outputs.
  logic w_unused;
  assign w_unused = &{1'b0, clk, reset, c_idle};

  assign out = w_dec;
  assign any = en;

`else

  logic [3:0] r_out;
  logic       r_any;

  // The code/en pair is sampled on a single edge, so a simultaneous change
  // of both inputs is reflected only as the new pair. No intermediate value
  // becomes visible. Reset takes priority and discards that edge's decode.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_out <= c_idle;
      r_any <= 1'b0;
    end else begin
      r_out <= w_dec;
      r_any <= en;
    end
  end

  assign out = r_out;
  assign any = r_any;

`endif

endmodule
`default_nettype wire

// File: tb/tb_dec2to4_en.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dec2to4_en
//  Purpose  : Self-checking bench for dec2to4_en. Two instances are driven
//             by the same inputs: one with INV_OUT=0 and one with INV_OUT=1.
//             Each instance is compared against an arithmetic reference
//             model after every clock step. The bench first runs directed
//             steps, then a randomized sequence.
//  Macro    : DEC2TO4_COMB_OUT_EN  switches the model to zero-latency outputs
//             that ignore reset
//  Revision : 1.0  initial release
// ============================================================================
module tb_dec2to4_en;

  logic       clk = 1'b0;
  logic       reset;
  logic       en;
  logic [1:0] code;
  logic [3:0] out_hi;
  logic       any_hi;
  logic [3:0] out_lo;
  logic       any_lo;

  int n_assert = 0;
  int n_fail   = 0;

  dec2to4_en #(.INV_OUT(0)) dut_hi (
    .clk   (clk),
    .reset (reset),
    .code  (code),
    .en    (en),
    .out   (out_hi),
    .any   (any_hi)
  );

  dec2to4_en #(.INV_OUT(1)) dut_lo (
    .clk   (clk),
    .reset (reset),
    .code  (code),
    .en    (en),
    .out   (out_lo),
    .any   (any_lo)
  );

  always #5 clk = ~clk;

  // Reference model. A line is asserted when the sampled enable is high and
  // reset did not win. The combinational build has no reset effect. The
  // asserted line carries weight 2**code. Active-low is the 4-bit complement
  // (15 - value).
  function automatic logic line_on(logic r, logic e);
`ifdef DEC2TO4_COMB_OUT_EN
    return e;
`else
    return e && !r;
`endif
  endfunction

  function automatic logic [3:0] model_out(int inv, logic r, logic e, logic [1:0] c);
    int v;
    v = line_on(r, e) ? (2 ** int'(c)) : 0;
    if (inv != 0) v = 15 - v;
    return 4'(v);
  endfunction

  task automatic check(string tag, logic [3:0] obs, logic [3:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Applies one input set away from the active edge, lets one rising edge
  // pass, and then checks both instances shortly after that edge.
  task automatic step(string tag, logic r, logic e, logic [1:0] c);
    logic [3:0] exp_hi;
    logic [3:0] exp_lo;
    logic [3:0] exp_cnt;
    @(negedge clk);
    reset = r;
    en    = e;
    code  = c;
    @(posedge clk);
    #1;
    exp_hi  = model_out(0, r, e, c);
    exp_lo  = model_out(1, r, e, c);
    exp_cnt = line_on(r, e) ? 4'd1 : 4'd0;
    check({tag, ".out_hi"}, out_hi, exp_hi);
    check({tag, ".any_hi"}, {3'b000, any_hi}, {3'b000, line_on(r, e)});
    check({tag, ".out_lo"}, out_lo, exp_lo);
    check({tag, ".any_lo"}, {3'b000, any_lo}, {3'b000, line_on(r, e)});
    check({tag, ".onehot_hi"}, 4'($countones(out_hi)), exp_cnt);
    check({tag, ".onehot_lo"}, 4'($countones(~out_lo)), exp_cnt);
  endtask

  initial begin
    reset = 1'b1;
    en    = 1'b1;
    code  = 2'd2;

    // The reset is held for two edges with a live decode request. After
    // release, the request is decoded.
    step("rst_hold0", 1'b1, 1'b1, 2'd2);
    step("rst_hold1", 1'b1, 1'b1, 2'd2);
    step("rst_rel",   1'b0, 1'b1, 2'd2);

    // Disabled sweep: every code stays inactive.
    for (int i = 0; i < 4; i++) step("dis_sweep", 1'b0, 1'b0, 2'(i));

    // Enabled sweep: each code selects its own line.
    for (int i = 0; i < 4; i++) step("en_sweep", 1'b0, 1'b1, 2'(i));

    // Simultaneous change of code and enable.
    step("simul_a", 1'b0, 1'b1, 2'd3);
    step("simul_b", 1'b0, 1'b0, 2'd1);
    step("simul_c", 1'b0, 1'b1, 2'd1);

    // Mid-operation reset, then resume on the first free edge.
    step("mid_rst",    1'b1, 1'b1, 2'd1);
    step("mid_resume", 1'b0, 1'b1, 2'd0);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 60; i++) begin
      step("rand",
           ($urandom_range(0, 7) == 0) ? 1'b1 : 1'b0,
           1'($urandom_range(0, 1)),
           2'($urandom_range(0, 3)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
